// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } accSize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } fsmState_t;

  // Byte lanes touched by an access of the given size at the given offset.
  // Misaligned combinations are never merged, so truncation there is harmless.
  function automatic logic [7:0] laneMask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (accSize_t'(size))
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: load extract/extend and store merge.
import mem_access_pkg::*;

module lane_align (
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        isUnsigned,
  input  logic [63:0] loadWord,
  input  logic [63:0] mergeBase,
  input  logic [63:0] wdata,
  output logic [63:0] loadData,
  output logic [63:0] mergedData
);

  logic [63:0] shifted;
  logic [63:0] wShift;
  logic [7:0]  mask;

  // Pull the addressed lane down to bit 0 and extend it.
  always_comb begin
    shifted  = loadWord >> {offset, 3'b000};
    loadData = shifted;
    case (accSize_t'(size))
      SIZE_BYTE: loadData = isUnsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SIZE_HALF: loadData = isUnsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_WORD: loadData = isUnsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default:   loadData = shifted;
    endcase
  end

  // Overlay the low bytes of the store data onto the addressed lanes only.
  always_comb begin
    mask       = laneMask(size, offset);
    wShift     = wdata << {offset, 3'b000};
    mergedData = mergeBase;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) mergedData[8*i +: 8] = wShift[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: aligns CPU byte/half/word/dword accesses onto a
// doubleword memory, doing read-modify-write for sub-word stores.
import mem_access_pkg::*;

module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  fsmState_t   state, nextState;
  logic [63:0] addrQ, wdataQ, dataQ, respRdataQ;
  logic [1:0]  sizeQ, rdCnt;
  logic        writeQ, unsQ, respMisQ;
  logic        reqMisaligned;
  logic [63:0] loadData, mergedData;

  assign req_ready       = (state == IDLE);
  assign resp_valid      = (state == RESP);
  assign mem_wr          = (state == WR);
  assign mem_addr        = {addrQ[63:3], 3'b000};
  assign mem_wdata       = mergedData;
  assign resp_rdata      = respRdataQ;
  assign resp_misaligned = respMisQ;

  // Alignment check on the live request, evaluated at the accepting edge.
  always_comb begin
    case (accSize_t'(req_size))
      SIZE_HALF:  reqMisaligned = req_addr[0];
      SIZE_WORD:  reqMisaligned = |req_addr[1:0];
      SIZE_DWORD: reqMisaligned = |req_addr[2:0];
      default:    reqMisaligned = 1'b0;
    endcase
  end

  lane_align uLaneAlign (
    .size       (sizeQ),
    .offset     (addrQ[2:0]),
    .isUnsigned (unsQ),
    .loadWord   (mem_rdata),
    .mergeBase  (dataQ),
    .wdata      (wdataQ),
    .loadData   (loadData),
    .mergedData (mergedData)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state: misaligned skips memory, dword stores skip the read.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (reqMisaligned)                                   nextState = RESP;
          else if (req_write && (req_size == 2'(SIZE_DWORD)))   nextState = WR;
          else                                                 nextState = RD;
        end
      end
      RD:      if (rdCnt == 2'd0) nextState = writeQ ? WR : RESP;
      WR:      nextState = RESP;
      default: nextState = IDLE;
    endcase
  end

  // Request capture, read-latency countdown and response data registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addrQ      <= '0;
      wdataQ     <= '0;
      sizeQ      <= '0;
      writeQ     <= 1'b0;
      unsQ       <= 1'b0;
      rdCnt      <= '0;
      dataQ      <= '0;
      respRdataQ <= '0;
      respMisQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
            sizeQ  <= req_size;
            writeQ <= req_write;
            unsQ   <= req_unsigned;
            rdCnt  <= 2'(READ_LAT);
            if (reqMisaligned) begin
              respRdataQ <= '0;
              respMisQ   <= 1'b1;
            end
          end
        end
        RD: begin
          if (rdCnt != 2'd0) begin
            rdCnt <= rdCnt - 2'd1;
          end else begin
            dataQ <= mem_rdata;
            if (!writeQ) begin
              respRdataQ <= loadData;
              respMisQ   <= 1'b0;
            end
          end
        end
        WR: begin
          respRdataQ <= '0;
          respMisQ   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a READ_LAT=1 doubleword memory model.
module tb_mem_access_unit;

  localparam int READ_LAT = 1;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, mem_wr;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [63:0] mem [0:63];
  logic [63:0] rdPipe;
  logic [5:0]  memIdx;

  int assertCount = 0;
  int failCount   = 0;

  always #5 Clk = ~Clk;

  mem_access_unit #(.READ_LAT(READ_LAT)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wr          (mem_wr),
    .mem_rdata       (mem_rdata)
  );

  assign memIdx    = 6'(mem_addr >> 3);
  assign mem_rdata = rdPipe;

  // One-cycle read pipeline and synchronous write.
  always @(posedge Clk) begin
    if (mem_wr) mem[memIdx] <= mem_wdata;
    rdPipe <= mem[memIdx];
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output int lat, output int wrMask, output logic [63:0] rdata,
                       output logic mis, output logic [63:0] wdSeen);
    lat = 0; wrMask = 0; rdata = '0; mis = 1'b0; wdSeen = '0;
    @(negedge Clk);
    for (int n = 0; n < 10 && !req_ready; n++) @(negedge Clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge Clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wdata;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      if (mem_wr) begin
        wrMask |= (1 << c);
        wdSeen = mem_wdata;
      end
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
        mis   = resp_misaligned;
      end else begin
        @(posedge Clk); #1;
      end
    end
  endtask

  int          lat, wrMask;
  logic [63:0] rdata, wdSeen;
  logic        mis, seen;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[32] = 64'h8877665544332211;
    rdPipe = '0;
    Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (3) @(posedge Clk);
    #1;
    checkVal("rst_req_ready",  64'(req_ready), 64'd1);
    checkVal("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkVal("rst_resp_rdata", resp_rdata, 64'd0);
    checkVal("rst_resp_mis",   64'(resp_misaligned), 64'd0);
    checkVal("rst_mem_addr",   mem_addr, 64'd0);
    checkVal("rst_mem_wdata",  mem_wdata, 64'd0);
    checkVal("rst_mem_wr",     64'(mem_wr), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Signed byte load at 0x107
    doReq(1'b0, 2'b00, 1'b0, 64'h107, 64'h0, lat, wrMask, rdata, mis, wdSeen);
    checkVal("lb_data", rdata, 64'hFFFFFFFFFFFFFF88);
    checkVal("lb_lat",  64'(lat), 64'd3);
    checkVal("lb_wr",   64'(wrMask), 64'd0);
    checkVal("lb_mis",  64'(mis), 64'd0);
    @(posedge Clk); #1;
    checkVal("lb_valid_drop", 64'(resp_valid), 64'd0);
    checkVal("lb_hold", resp_rdata, 64'hFFFFFFFFFFFFFF88);

    // Unsigned half load at 0x106
    doReq(1'b0, 2'b01, 1'b1, 64'h106, 64'h0, lat, wrMask, rdata, mis, wdSeen);
    checkVal("lhu_data", rdata, 64'h0000000000008877);
    checkVal("lhu_lat",  64'(lat), 64'd3);

    // Signed word load at 0x104
    doReq(1'b0, 2'b10, 1'b0, 64'h104, 64'h0, lat, wrMask, rdata, mis, wdSeen);
    checkVal("lw_data", rdata, 64'hFFFFFFFF88776655);

    // Byte store 0xAB at 0x102 (upper wdata bytes must not leak)
    doReq(1'b1, 2'b00, 1'b0, 64'h102, 64'h123456789ABCDEAB, lat, wrMask, rdata, mis, wdSeen);
    checkVal("sb_wr_cycles", 64'(wrMask), 64'(1 << 3));
    checkVal("sb_wdata", wdSeen, 64'h8877665544AB2211);
    checkVal("sb_lat",   64'(lat), 64'd4);
    checkVal("sb_rdata", rdata, 64'd0);
    checkVal("sb_mem",   mem[32], 64'h8877665544AB2211);

    // Misaligned word load at 0x102
    doReq(1'b0, 2'b10, 1'b0, 64'h102, 64'h0, lat, wrMask, rdata, mis, wdSeen);
    checkVal("mis_flag",  64'(mis), 64'd1);
    checkVal("mis_rdata", rdata, 64'd0);
    checkVal("mis_lat",   64'(lat), 64'd1);
    checkVal("mis_wr",    64'(wrMask), 64'd0);
    checkVal("mis_mem",   mem[32], 64'h8877665544AB2211);

    // Doubleword store then load at 0x108
    doReq(1'b1, 2'b11, 1'b0, 64'h108, 64'h0123456789ABCDEF, lat, wrMask, rdata, mis, wdSeen);
    checkVal("sd_wr_cycles", 64'(wrMask), 64'(1 << 1));
    checkVal("sd_lat", 64'(lat), 64'd2);
    checkVal("sd_mem", mem[33], 64'h0123456789ABCDEF);
    doReq(1'b0, 2'b11, 1'b0, 64'h108, 64'h0, lat, wrMask, rdata, mis, wdSeen);
    checkVal("ld_data", rdata, 64'h0123456789ABCDEF);
    checkVal("ld_lat",  64'(lat), 64'd3);

    // Half store 0xBEEF at 0x10C
    doReq(1'b1, 2'b01, 1'b0, 64'h10C, 64'hFFFF_FFFF_FFFF_BEEF, lat, wrMask, rdata, mis, wdSeen);
    checkVal("sh_lat", 64'(lat), 64'd4);
    checkVal("sh_mem", mem[33], 64'h0123BEEF89ABCDEF);

    // Reset during RD of a byte store to 0x100, with requests offered under reset
    seen = 1'b0;
    @(negedge Clk);
    for (int n = 0; n < 10 && !req_ready; n++) @(negedge Clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 64'h100; req_wdata = 64'h55;
    @(posedge Clk); #3;
    Reset = 1'b1;
    #1;
    checkVal("abort_ready_in_rst", 64'(req_ready), 64'd1);
    seen = seen | mem_wr | resp_valid;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      seen = seen | mem_wr | resp_valid;
    end
    @(negedge Clk);
    req_valid = 1'b0;
    Reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clk); #1;
      seen = seen | mem_wr | resp_valid;
    end
    checkVal("abort_no_activity", 64'(seen), 64'd0);
    checkVal("abort_ready", 64'(req_ready), 64'd1);
    checkVal("abort_mem", mem[32], 64'h8877665544AB2211);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, memory read latency in cycles, legal values 1..3.
REQ-002 SHALL have port Clk  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CPU request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend loads (ignored for doubleword and stores).
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  64  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  64  extended load data.
REQ-013 SHALL have port resp_misaligned  output  1  request rejected as misaligned.
REQ-014 SHALL have port mem_addr  output  64  doubleword-aligned memory address.
REQ-015 SHALL have port mem_wdata  output  64  full doubleword to write.
REQ-016 SHALL have port mem_wr  output  1  memory write enable.
REQ-017 SHALL have port mem_rdata  input  64  memory read data, valid READ_LAT cycles after mem_addr is stable.

Function
REQ-018 SHALL use FSM states IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept on a rising edge with req_valid && req_ready and SHALL register all req_* fields at that edge; later changes to req_* SHALL be ignored.
REQ-020 SHALL drive mem_addr = {addr[63:3],3'b000} from the registered address in every non-IDLE state.
REQ-021 SHALL flag misalignment when addr[0]≠0 for half, addr[1:0]≠0 for word, or addr[2:0]≠0 for doubleword; misaligned requests SHALL go IDLE->RESP with resp_misaligned=1 and resp_rdata=0, with no memory access.
REQ-022 Loads SHALL go IDLE->RD for READ_LAT+1 cycles, capture mem_rdata at the last RD edge, then go to RESP.
REQ-023 Load data SHALL be the lane selected by addr[2:0] and size, sign-extended unless req_unsigned=1.
REQ-024 Doubleword stores SHALL go IDLE->WR->RESP with mem_wdata=req_wdata.
REQ-025 Byte, half and word stores SHALL go IDLE->RD for READ_LAT+1 cycles, then WR, then RESP (read-modify-write).
REQ-026 The merged write data SHALL replace only the addressed lanes of the captured doubleword with the low bytes of req_wdata.
REQ-027 mem_wr SHALL be 1 only in WR, for exactly one cycle per store.
REQ-028 resp_valid SHALL be 1 only in RESP, and RESP SHALL always return to IDLE.
REQ-029 Latency L (resp_valid high in the L-th cycle after the accepting edge) SHALL be: misaligned 1, doubleword store 2, load READ_LAT+2, sub-word store READ_LAT+3.
REQ-030 resp_rdata SHALL be 0 for stores.
REQ-031 resp_rdata and resp_misaligned SHALL be valid only while resp_valid=1 and SHALL be held until the next response.

Reset
REQ-032 Reset SHALL asynchronously force IDLE and clear all registers.
REQ-033 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_addr=0, mem_wdata=0, mem_wr=0.
REQ-034 Reset mid-operation SHALL abort the request: no mem_wr, no resp_valid.
REQ-035 Requests SHALL be ignored while Reset=1.

Structure
REQ-036 A shared package mem_access_pkg SHALL hold the size encoding enum, the FSM state enum, and a lane byte-mask function.
REQ-037 Lane extract/extend and store merge SHALL be one combinational sub-module, lane_align.
REQ-038 The FSM, RD counter and data registers SHALL remain in mem_access_unit.

Verification (READ_LAT=1; memory preloaded with 0x100 = 0x8877665544332211)
REQ-039 Signed byte load at 0x107 -> resp_rdata=0xFFFFFFFFFFFFFF88, L=3, mem_wr never 1.
REQ-040 Unsigned half load at 0x106 -> resp_rdata=0x0000000000008877, L=3.
REQ-041 Byte store of 0xAB at 0x102 -> mem_wr high in cycle 3 only, mem_wdata=0x8877665544AB2211, resp in cycle 4.
REQ-042 Word load at 0x102 -> resp_misaligned=1, resp_rdata=0, L=1, mem_wr never 1, memory unchanged.
REQ-043 Doubleword store of 0x0123456789ABCDEF at 0x108 -> mem_wr in cycle 1, resp in cycle 2; a following load at 0x108 returns the same value.
REQ-044 Reset pulsed during RD of a byte store to 0x100 -> no mem_wr, no resp_valid, req_ready=1 after release, 0x100 unchanged.
